// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: req/ack data port, lane steering, load formatting.
// Optional MISALIGN_TRAP_EN: trap misaligned accesses instead of issuing them.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        StallM,
  output logic [31:0] ReadDataW,
  output logic        load_doneW,
  output logic        bus_err,
  output logic        misalign_exc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    f3_q;
  logic [1:0]    a_q;
  logic [1:0]    a;
  logic          op, is_b, is_h;
  logic          issue, fin, abort;
  logic [3:0]    be_n;
  logic [31:0]   wd_n;

  function automatic logic [31:0] fmt(
    input logic [31:0] w,
    input logic [2:0]  f3,
    input logic [1:0]  la
  );
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> {la, 3'b000};
    b  = sh[7:0];
    h  = la[1] ? w[31:16] : w[15:0];
    unique case (f3)
      3'b000:  fmt = {{24{b[7]}}, b};
      3'b001:  fmt = {{16{h[15]}}, h};
      3'b100:  fmt = {24'h0, b};
      3'b101:  fmt = {16'h0, h};
      default: fmt = w;
    endcase
  endfunction

  assign a  = ALUResultM[1:0];
  assign op = MemReadM | MemWriteM;

  // Stores only know SB/SH; loads also have the unsigned byte/half codes.
  always_comb begin
    if (MemWriteM) begin
      is_b = (funct3M == 3'b000);
      is_h = (funct3M == 3'b001);
    end else begin
      is_b = (funct3M[1:0] == 2'b00);
      is_h = (funct3M[1:0] == 2'b01);
    end
  end

  always_comb begin
    be_n = 4'hF;
    wd_n = WriteDataM;
    unique case (1'b1)
      is_b: begin
        be_n = 4'b0001 << a;
        wd_n = {4{WriteDataM[7:0]}};
      end
      is_h: begin
        be_n = a[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic mis, trap, mis_q;
  assign mis = (is_h & a[0]) | (~is_b & ~is_h & (a != 2'b00));
`endif

  always_comb begin
    state_d = state_q;
    StallM  = 1'b0;
    issue   = 1'b0;
    fin     = 1'b0;
    abort   = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (op) begin
`ifdef MISALIGN_TRAP_EN
          if (mis) begin
            trap = 1'b1;
          end else begin
            issue   = 1'b1;
            StallM  = 1'b1;
            state_d = BUSY;
          end
`else
          issue   = 1'b1;
          StallM  = 1'b1;
          state_d = BUSY;
`endif
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          fin     = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          StallM  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dmem_req = (state_q == BUSY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      f3_q       <= '0;
      a_q        <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      ReadDataW  <= '0;
      load_doneW <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_doneW <= 1'b0;
      bus_err    <= 1'b0;
      if (issue) begin
        dmem_addr  <= {ALUResultM[31:2], 2'b00};
        dmem_be    <= be_n;
        dmem_wdata <= wd_n;
        dmem_we    <= MemWriteM;
        f3_q       <= funct3M;
        a_q        <= a;
        cnt_q      <= '0;
      end else if (fin || abort) begin
        cnt_q   <= '0;
        dmem_be <= '0;
        dmem_we <= 1'b0;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (fin && !dmem_we) begin
        ReadDataW  <= fmt(dmem_rdata, f3_q, a_q);
        load_doneW <= 1'b1;
      end
      if (abort) begin
        bus_err <= 1'b1;
        if (!dmem_we) ReadDataW <= '0;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= trap;
  end
  assign misalign_exc = mis_q;
`else
  assign misalign_exc = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu against a byte-level memory model.
// Follows MISALIGN_TRAP_EN when defined for the build.
module tb_mem_stage_lsu;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        StallM;
  logic [31:0] ReadDataW;
  logic        load_doneW, bus_err, misalign_exc;

  mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .funct3M(funct3M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .StallM(StallM),
    .ReadDataW(ReadDataW), .load_doneW(load_doneW),
    .bus_err(bus_err), .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] mem [256];
  logic [31:0] exp_rd;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input bit wr, input logic [2:0] f3);
    if (wr) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic int lane_off(input int n, input int a);
    if (n == 1) return a;
    if (n == 2) return (a / 2) * 2;
    return 0;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3,
                                           input logic [31:0] w,
                                           input int a);
    int n, off;
    logic [31:0] mask, v;
    n = nbytes(1'b0, f3);
    off = lane_off(n, a);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
    v = (w >> (8 * off)) & mask;
    if (n < 4 && f3[2] == 1'b0 && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic do_op(input bit rd, input bit wr,
                       input logic [2:0] f3,
                       input logic [31:0] addr,
                       input logic [31:0] wd,
                       input int dly);
    int n, a, off, busy, idx;
    bit trap, ld, acked;
    logic [31:0] word, ebe, ewd;
    a = int'(addr[1:0]);
    n = nbytes(wr, f3);
    off = lane_off(n, a);
    ld = rd && !wr;
    idx = int'(addr[9:2]);
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = (n == 2 && a % 2 == 1) || (n == 4 && a != 0);
`endif
    ebe = ((32'd1 << n) - 1) << off;
    ewd = (n == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
          (n == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    @(posedge clk); #1;
    MemReadM = rd; MemWriteM = wr; funct3M = f3;
    ALUResultM = addr; WriteDataM = wd;
    @(negedge clk);
    chk("idle_stall", StallM, !trap);
    chk("idle_req", dmem_req, 0);
    @(posedge clk); #1;
    if (trap) begin
      MemReadM = 0; MemWriteM = 0;
      @(negedge clk);
      chk("mis_exc", misalign_exc, 1);
      chk("mis_req", dmem_req, 0);
      chk("mis_rd", ReadDataW, exp_rd);
      return;
    end
    busy = 0;
    acked = 1'b0;
    word = 32'h0;
    while (1) begin
      busy++;
      if (busy == dly) begin
        dmem_ack = 1'b1;
        word = mem[idx];
        dmem_rdata = word;
        acked = 1'b1;
      end
      @(negedge clk);
      chk("busy_req", dmem_req, 1);
      if (busy == 1) begin
        chk("addr", dmem_addr, addr & 32'hFFFF_FFFC);
        chk("we", dmem_we, wr);
        if (wr) begin
          chk("be", dmem_be, ebe);
          chk("wdata", dmem_wdata, ewd);
        end
      end
      if (acked || busy == TO) begin
        chk("end_stall", StallM, 0);
        break;
      end
      chk("busy_stall", StallM, 1);
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0; MemReadM = 0; MemWriteM = 0;
    dmem_rdata = $urandom;
    @(negedge clk);
    chk("post_req", dmem_req, 0);
    if (acked) begin
      if (wr)
        for (int i = 0; i < n; i++)
          mem[idx][8 * (off + i) +: 8] = wd[8 * i +: 8];
      else
        exp_rd = load_val(f3, word, a);
      chk("done", load_doneW, ld);
      chk("err", bus_err, 0);
    end else begin
      if (ld) exp_rd = 32'h0;
      chk("err", bus_err, 1);
      chk("done_to", load_doneW, 0);
    end
    chk("rdw", ReadDataW, exp_rd);
    chk("mis0", misalign_exc, 0);
  endtask

  initial begin
    reset = 1'b1;
    MemReadM = 0; MemWriteM = 0; funct3M = 0;
    ALUResultM = 0; WriteDataM = 0;
    dmem_rdata = 0; dmem_ack = 0;
    exp_rd = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    repeat (2) @(negedge clk);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_rdw", ReadDataW, 0);
    chk("rst_done", load_doneW, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_mis", misalign_exc, 0);
    chk("rst_stall", StallM, 0);
    reset = 1'b0;

    do_op(0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 3);
    chk("sw_mem", mem[65], 32'hDEADBEEF);
    do_op(0, 1, 3'b000, 32'h103, 32'h0000_00A5, 1);
    chk("sb_mem", mem[64][31:24], 32'hA5);
    mem[64] = 32'h0080_FF00;
    do_op(1, 0, 3'b000, 32'h102, 32'h0, 1);
    chk("lb_vec", ReadDataW, 32'hFFFF_FF80);
    mem[64] = 32'h8001_0000;
    do_op(1, 0, 3'b101, 32'h102, 32'h0, 2);
    chk("lhu_vec", ReadDataW, 32'h0000_8001);
    do_op(1, 0, 3'b001, 32'h102, 32'h0, 1);
    chk("lh_vec", ReadDataW, 32'hFFFF_8001);
    do_op(1, 0, 3'b010, 32'h108, 32'h0, 0);
    chk("to_rdw", ReadDataW, 32'h0);
    mem[64] = 32'h1234_5678;
    do_op(1, 0, 3'b010, 32'h101, 32'h0, 1);
    do_op(1, 1, 3'b000, 32'h10A, 32'h0000_0077, 2);

    // ack while idle must not start anything
    @(posedge clk); #1;
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("idle_ack_stall", StallM, 0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_req", dmem_req, 0);
    chk("idle_ack_done", load_doneW, 0);

    for (int t = 0; t < 200; t++) begin
      bit rd, wr;
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      do_op(rd, wr, 3'($urandom), $urandom,
            $urandom, $urandom_range(0, TO + 2));
    end

    // reset in the middle of an access
    @(posedge clk); #1;
    MemReadM = 1; funct3M = 3'b010; ALUResultM = 32'h200;
    @(posedge clk); #1;
    MemReadM = 0;
    @(negedge clk);
    chk("mid_req", dmem_req, 1);
    #1 reset = 1'b1;
    #1 chk("mid_rst_req", dmem_req, 0);
    #2 reset = 1'b0;
    exp_rd = 32'h0;
    @(negedge clk);
    chk("mid_done", load_doneW, 0);
    chk("mid_err", bus_err, 0);
    chk("mid_rdw", ReadDataW, exp_rd);
    @(negedge clk);
    chk("mid_req2", dmem_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
